instr_fetch_buffer: RTL and testbench

- Downstream neighbour of the 8-bit program counter; consumes `pc` each cycle.
- Issues reads to a synchronous instruction memory with 1-cycle read latency.
- Tags each returned instruction with its PC and buffers the pairs in a small FIFO.
- Presents the pairs to the FPU decode stage over a valid/ready handshake, and back-pressures the PC with `pc_hold`.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/instr_fetch_buffer_if.sv | 26 ++
 rtl/fetch_fifo.sv | 93 +++++++++
 rtl/fetch_fifo_chk.sv | 12 +
 rtl/instr_fetch_buffer.sv | 105 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 197 +++++++++++++++++++
 6 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch buffer and its FIFO.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle between the fetch buffer and its PC, instruction memory and decode neighbours.
interface instr_fetch_buffer_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  pc;
    logic               pc_hold;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               flush;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        output pc, imem_rdata, flush, instr_ready,
        input  pc_hold, imem_en, imem_addr, instr_valid, instr_data, instr_pc
    );

    modport slave (
        input  pc, imem_rdata, flush, instr_ready,
        output pc_hold, imem_en, imem_addr, instr_valid, instr_data, instr_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of PC-tagged instructions with push/pop/clear.
// When empty the head output keeps showing the most recently removed entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     last_q, last_d;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? last_q : mem_q[rd_q];

    // Pointer, occupancy and held-head next state.
    always_comb begin
        push_s  = push_i & ~clear_i;
        pop_s   = pop_i & ~clear_i & ~empty_o;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        last_d  = last_q;
        if (clear_i) begin
            rd_d    = PTR_W'(0);
            wr_d    = PTR_W'(0);
            count_d = CNT_W'(0);
            last_d  = head_o;
        end else begin
            if (push_s) begin
                wr_d = wr_q + PTR_W'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d   = rd_q + PTR_W'(1);
                last_d = mem_q[rd_q];
            end else begin
                rd_d   = rd_q;
                last_d = last_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= PTR_W'(0);
            wr_q    <= PTR_W'(0);
            count_q <= CNT_W'(0);
            last_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_fifo_chk.sv
// Run-time checker: a return must never be pushed into a full fetch FIFO.
module fetch_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push_i,
    input logic full_i
);

    // Credit accounting guarantees a free slot for every in-flight return.
    push_into_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Credit-based instruction fetch buffer between the PC, a 1-cycle instruction memory and decode.
// Optional macro FETCH_PERF_EN adds a saturating stall_cycles counter output.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_buffer_if.slave bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count_s;
    logic              full_s, empty_s;
    fetch_entry_t      head_s, push_data_s;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              credit_s, issue_s, push_s, pop_s;

    // Issue/return control; an in-flight read already owns a slot, so credit counts it.
    always_comb begin
        credit_s    = ((count_s + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
        issue_s     = credit_s & ~bus.flush & reset;
        push_s      = inflight_q & ~bus.flush;
        pop_s       = ~empty_s & bus.instr_ready & ~bus.flush;
        inflight_d  = issue_s;
        push_data_s = '{pc: tag_q, instr: bus.imem_rdata};
        if (issue_s) begin
            tag_d = bus.pc;
        end else begin
            tag_d = tag_q;
        end
    end

    assign bus.imem_en     = issue_s;
    assign bus.pc_hold     = ~issue_s;
    assign bus.imem_addr   = bus.pc;
    assign bus.instr_valid = ~empty_s;
    assign bus.instr_data  = head_s.instr;
    assign bus.instr_pc    = head_s.pc;

    // In-flight flag and PC tag of the outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            tag_q      <= ADDR_W'(0);
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .clear_i     (bus.flush),
        .head_o      (head_s),
        .count_o     (count_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    fetch_fifo_chk u_fifo_chk (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (push_s),
        .full_i (full_s)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Count held-PC cycles that are not caused by a flush, saturating.
    always_comb begin
        if (!issue_s && !bus.flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'h0001;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer with an upstream PC and 1-cycle memory model.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   issue_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch_buffer_if bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] stall_cycles;
`endif

    instr_fetch_buffer #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshake before the edge, then model PC advance and memory read data.
    task automatic tick();
        logic              h;
        logic              en;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        h  = bus.pc_hold;
        en = bus.imem_en;
        a  = bus.imem_addr;
        if (en) issue_cnt++;
        @(posedge clk);
        #1;
        if (en) bus.imem_rdata = {24'h000000, a};
        if (!h) bus.pc = bus.pc + 8'h01;
        #1;
    endtask

    task automatic do_reset(input logic [7:0] start_pc, input logic rdy);
        reset           = 1'b0;
        bus.pc          = start_pc;
        bus.flush       = 1'b0;
        bus.instr_ready = rdy;
        bus.imem_rdata  = 32'h0;
        issue_cnt       = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        bus.pc          = 8'h00;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;
        bus.imem_rdata  = 32'h0;
        #12;
        check_value("rst_valid", bus.instr_valid, 1'b0);
        check_value("rst_data",  bus.instr_data, 32'h0);
        check_value("rst_pc",    bus.instr_pc, 8'h00);
        check_value("rst_hold",  bus.pc_hold, 1'b1);
        check_value("rst_en",    bus.imem_en, 1'b0);

        // Streaming
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_value("str_issue", bus.imem_en, 1'b1);
        check_value("str_addr",  bus.imem_addr, 8'h00);
        tick();
        check_value("str_lat1", bus.instr_valid, 1'b0);
        tick();
        check_value("str_valid", bus.instr_valid, 1'b1);
        check_value("str_pc0",   bus.instr_pc, 8'h00);
        check_value("str_data0", bus.instr_data, 32'h0);
        for (int k = 1; k < 6; k++) begin
            tick();
            check_value("str_pc",    bus.instr_pc, k);
            check_value("str_data",  bus.instr_data, k);
            check_value("str_hold",  bus.pc_hold, 1'b0);
            check_value("str_vld",   bus.instr_valid, 1'b1);
        end

        // Back-pressure
        do_reset(8'h00, 1'b0);
        repeat (8) tick();
        check_value("bp_issues", issue_cnt, 4);
        check_value("bp_hold",   bus.pc_hold, 1'b1);
        check_value("bp_count",  dut.u_fifo.count_q, 3'd4);
        check_value("bp_pcval",  bus.pc, 8'h04);
        check_value("bp_head",   bus.instr_pc, 8'h00);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        #1;
        check_value("bp_head1",  bus.instr_pc, 8'h01);
        check_value("bp_reiss",  bus.imem_en, 1'b1);
        check_value("bp_readdr", bus.imem_addr, 8'h04);
        tick();
        check_value("bp_hold2",  bus.pc_hold, 1'b1);
        check_value("bp_issue5", issue_cnt, 5);
        check_value("bp_pc5",    bus.pc, 8'h05);

        // Flush with 3 buffered and 1 in flight
        do_reset(8'h00, 1'b0);
        repeat (4) tick();
        check_value("fl_count", dut.u_fifo.count_q, 3'd3);
        check_value("fl_infl",  dut.inflight_q, 1'b1);
        bus.flush = 1'b1;
        bus.pc    = 8'h40;
        #1;
        check_value("fl_en",   bus.imem_en, 1'b0);
        check_value("fl_hold", bus.pc_hold, 1'b1);
        tick();
        bus.flush = 1'b0;
        #1;
        check_value("fl_valid", bus.instr_valid, 1'b0);
        check_value("fl_empty", dut.u_fifo.count_q, 3'd0);
        check_value("fl_addr",  bus.imem_addr, 8'h40);
        check_value("fl_reiss", bus.imem_en, 1'b1);
        bus.instr_ready = 1'b1;
        tick();
        check_value("fl_valid2", bus.instr_valid, 1'b0);
        tick();
        check_value("fl_valid3", bus.instr_valid, 1'b1);
        check_value("fl_pc",     bus.instr_pc, 8'h40);
        check_value("fl_data",   bus.instr_data, 32'h40);

        // PC wrap-around
        do_reset(8'hFE, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'hFE + k[7:0];
            check_value("wr_pc",   bus.instr_pc, exp_pc);
            check_value("wr_data", bus.instr_data, {24'h000000, exp_pc});
            check_value("wr_vld",  bus.instr_valid, 1'b1);
            tick();
        end

        // Asynchronous reset with 2 entries buffered
        do_reset(8'h00, 1'b0);
        repeat (3) tick();
        check_value("ar_count", dut.u_fifo.count_q, 3'd2);
        #2;
        reset = 1'b0;
        #1;
        check_value("ar_valid", bus.instr_valid, 1'b0);
        check_value("ar_hold",  bus.pc_hold, 1'b1);
        check_value("ar_en",    bus.imem_en, 1'b0);
        check_value("ar_cnt0",  dut.u_fifo.count_q, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_value("ar_valid2", bus.instr_valid, 1'b0);
        check_value("ar_cnt1",   dut.u_fifo.count_q, 3'd0);
        check_value("ar_en2",    bus.imem_en, 1'b1);

`ifdef FETCH_PERF_EN
        // Stall counter
        do_reset(8'h00, 1'b0);
        repeat (4) tick();
        repeat (24) tick();
        check_value("pf_ge20",  (stall_cycles >= 16'd20), 1'b1);
        check_value("pf_exact", stall_cycles, 16'd24);
        force dut.stall_q = 16'hFFFE;
        #1;
        release dut.stall_q;
        repeat (3) tick();
        check_value("pf_sat", stall_cycles, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
